// File: rtl/issue_unit.sv
// Tomasulo issue stage: decodes one queued instruction per cycle, allocates an RS tag,
// reads operands through the RAT (with same-cycle CDB bypass) and registers one issue record.
module issue_unit #(
  parameter int ADD_RS = 3,
  parameter int MUL_RS = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] q_data,
  input  logic        q_valid,
  output logic        q_read,
  output logic        iss_valid,
  output logic [2:0]  iss_tag,
  output logic [2:0]  iss_op,
  output logic [15:0] iss_vj,
  output logic [15:0] iss_vk,
  output logic [2:0]  iss_qj,
  output logic [2:0]  iss_qk,
  output logic        stall,
  input  logic        cdb_valid,
  input  logic [2:0]  cdb_tag,
  input  logic [15:0] cdb_data
);

  localparam int NTAG = ADD_RS + MUL_RS;

  logic [15:4]   ir_reg;
  logic          ir_valid_reg;
  logic [NTAG:1] busy_reg;
  logic [2:0]    rat_reg  [8];
  logic [15:0]   regs_reg [8];

  // The low nibble of the instruction word carries no information.
  logic unused_low;
  assign unused_low = ^q_data[3:0];

  logic [2:0] ir_op, ir_rd;
  logic [2:0] src [2];
  logic       is_nop, is_mul;

  assign ir_op  = ir_reg[15:13];
  assign ir_rd  = ir_reg[12:10];
  assign src[0] = ir_reg[9:7];
  assign src[1] = ir_reg[6:4];
  assign is_nop = ir_op[2];
  assign is_mul = ir_op[1];

  logic       free_found;
  logic [2:0] free_tag;

  // Descending scan so the lowest free tag of the class is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_tag   = 3'd0;
    for (int t = NTAG; t >= 1; t--) begin
      if (((t > ADD_RS) == is_mul) && !busy_reg[t]) begin
        free_found = 1'b1;
        free_tag   = 3'(t);
      end
    end
  end

  logic issue_now, issue_rs, accept, cdb_hit;

  assign issue_now = ir_valid_reg & (is_nop | free_found);
  assign issue_rs  = issue_now & ~is_nop;
  assign stall     = ir_valid_reg & ~is_nop & ~free_found;
  assign q_read    = ~ir_valid_reg | issue_now;
  assign accept    = q_read & q_valid;
  assign cdb_hit   = cdb_valid & (cdb_tag != 3'd0);

  logic [15:0] op_v [2];
  logic [2:0]  op_q [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_opnd
      logic [2:0] producer;
      always_comb begin
        producer = rat_reg[src[gi]];
        op_v[gi] = 16'd0;
        op_q[gi] = producer;
        if (producer == 3'd0) begin
          op_v[gi] = regs_reg[src[gi]];
        end else if (cdb_valid && cdb_tag == producer) begin
          op_v[gi] = cdb_data;
          op_q[gi] = 3'd0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
      busy_reg     <= '0;
      for (int i = 0; i < 8; i++) begin
        rat_reg[i]  <= 3'd0;
        regs_reg[i] <= 16'(i);
      end
      iss_valid <= 1'b0;
      iss_tag   <= 3'd0;
      iss_op    <= 3'd0;
      iss_vj    <= 16'd0;
      iss_vk    <= 16'd0;
      iss_qj    <= 3'd0;
      iss_qk    <= 3'd0;
    end else begin
      if (accept) begin
        ir_reg       <= q_data[15:4];
        ir_valid_reg <= 1'b1;
      end else if (issue_now) begin
        ir_valid_reg <= 1'b0;
      end

      iss_valid <= issue_rs;
      if (issue_rs) begin
        iss_tag <= free_tag;
        iss_op  <= ir_op;
        iss_vj  <= op_v[0];
        iss_qj  <= op_q[0];
        iss_vk  <= op_v[1];
        iss_qk  <= op_q[1];
      end

      // Allocation comes after the CDB clear so a set always wins on the same tag.
      for (int t = 1; t <= NTAG; t++) begin
        if (cdb_hit && cdb_tag == 3'(t)) busy_reg[t] <= 1'b0;
        if (issue_rs && free_tag == 3'(t)) busy_reg[t] <= 1'b1;
      end

      for (int r = 0; r < 8; r++) begin
        if (cdb_hit && rat_reg[r] == cdb_tag) begin
          regs_reg[r] <= cdb_data;
          rat_reg[r]  <= 3'd0;
        end
      end
      if (issue_rs) rat_reg[ir_rd] <= free_tag;
    end
  end

endmodule

// File: doc/issue_unit.md
# issue_unit

Tomasulo issue stage sitting directly downstream of the instruction queue. Each cycle it pops one 16-bit instruction word from the queue and decodes it. It allocates a free reservation-station (RS) tag of the correct class, reads operands from its register file or register-status table (RAT), and presents one registered issue record to the reservation stations. It also snoops the common data bus (CDB) to retire tags, update registers and forward results into operands issued in the same cycle.

## Interface
- ADD_RS, 3, add/sub RS entries; tags 1..ADD_RS
- MUL_RS, 2, mul/div RS entries; tags ADD_RS+1..ADD_RS+MUL_RS; ADD_RS+MUL_RS ≤ 7
- clock  in  1  sole clock; all state changes on rising edge
- reset_n  in  1  asynchronous, active-low reset
- q_data  in  16  instruction word from queue
- q_valid  in  1  q_data valid this cycle
- q_read  out  1  combinational pop request: !ir_valid | issue_now
- iss_valid  out  1  registered; one-cycle pulse per issued instruction
- iss_tag  out  3  RS tag allocated
- iss_op  out  3  opcode
- iss_vj, iss_vk  out  16  operand values (valid when matching Q = 0)
- iss_qj, iss_qk  out  3  producing tags; 0 = value ready
- stall  out  1  combinational: ir_valid & no free RS of required class
- cdb_valid  in  1  CDB broadcast valid
- cdb_tag  in  3  broadcasting tag (0 ignored)
- cdb_data  in  16  broadcast result

## Operation
- Word format: [15:13] op, [12:10] rd, [9:7] rs, [6:4] rt, [3:0] ignored.
- Op 000 ADD, 001 SUB → add class; 010 MUL, 011 DIV → mul class; 1xx → NOP: consumed, no issue, no tag, no RAT change.
- State: IR (16b) plus ir_valid; busy[1..7]; RAT[0..7] (3b each); R[0..7] (16b each).
- Reset: ir_valid=0, busy=0, RAT=0, R[i]=i, all iss_* = 0. stall=0 and q_read=1 while in reset.
- Accept: an edge with q_read & q_valid loads IR and sets ir_valid. An edge with issue_now and no accept clears ir_valid.
- issue_now = ir_valid & (NOP | a free tag exists in the class).
- Allocation: lowest-numbered free tag within the class.
- On an issuing edge:
  - register iss_valid=1, iss_op, iss_tag;
  - set busy[tag] and RAT[rd]=tag.
- Operand j (k identical with rt):
  - if RAT[rs]=0: vj=R[rs], qj=0;
  - else if cdb_valid & cdb_tag=RAT[rs]: vj=cdb_data, qj=0 (bypass);
  - else vj=0, qj=RAT[rs].
- CDB, every edge with cdb_valid and cdb_tag≠0:
  - clear busy[cdb_tag];
  - for every r with RAT[r]=cdb_tag: R[r]=cdb_data and RAT[r]=0.
- Same-edge conflicts:
  - The issue write to RAT[rd] wins over the CDB clear of RAT[rd]. R[rd] still takes cdb_data if the old RAT[rd] matched.
  - The CDB freeing a tag does not make that tag allocatable until the next edge (busy is sampled pre-edge).
  - Source operand reads use the pre-edge RAT, so rd=rs reads the old producer, not the new tag.
- Broadcast of a tag that is not busy: no effect beyond RAT/R matching (none).

## Timing
- Queue to issue latency: word accepted at edge N, iss_valid high after edge N+1 if an RS is free; back-to-back sustained rate of 1 instruction/cycle.
- iss_valid is high exactly one cycle per issue; iss_* hold last values when iss_valid=0.
- While stalled: IR held, q_read=0, iss_valid=0; issue occurs on the first edge after the blocking tag is freed.
- reset_n low mid-operation: immediate clear of all state and outputs; in-flight IR is discarded.

## Test plan
- Reset → iss_valid=0, stall=0, q_read=1, R[i]=i, RAT all 0 (check via operand values of subsequent issues).
- Push 0x0530 (ADD R1,R2,R3) → next cycle iss_valid=1, iss_tag=1, iss_op=0, vj=2, vk=3, qj=qk=0.
- Then 0x30A0 (SUB R4,R1,R2) → iss_tag=2, qj=1, vk=2, qk=0. Repeat with cdb_valid=1, cdb_tag=1, cdb_data=0x0005 on the issuing cycle → vj=5, qj=0; later readers of R1 get 5.
- Four ADDs back-to-back, no CDB → tags 1,2,3 issued, then stall=1 and q_read=0. Drive CDB tag 2 → fourth issues with tag 2 on the following cycle.
- WAW: MUL R1 (0x4530, tag 4), then ADD R1 (0x0530, tag 1). CDB tag 4 data 0x00AA → R1 unchanged, RAT[1]=1. CDB tag 1 data 0x0007 → R1=7.
- Assert reset_n low while stalled with busy tags → all outputs 0 immediately; the next ADD after release gets tag 1.
